edf_memory_scheduler: RTL and testbench
=======================================

# edf_memory_scheduler

Earliest-deadline-first arbiter for the MemorEDF queueing domain. It tracks a relative-deadline countdown for each per-core pointer queue and picks the non-empty queue whose deadline is nearest. It drives `core_id` and the `scheduler_to_queues_ready` pulse into the queueing domain, then waits for the `queues_to_serializer_valid` pulse before re-arbitrating. It sits between the queueing domain and the serializer, one instance per MemorEDF port.

## Interface
- `NUMBER_OF_QUEUES`, 4: number of per-core queues arbitrated; must be ≥2.
- `REGISTER_SIZE`, 32: width of period registers and slack counters.
- `clock` in 1: single clock for the whole block.
- `reset` in 1: synchronous, active-high. All state clears on the clock edge where it is sampled high.
- `queues_period` in `[NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]`: relative deadline per queue, in cycles. Quasi-static; sampled only on reload.
- `empty` in `NUMBER_OF_QUEUES`: per-queue empty flags from the queueing domain.
- `serializer_ready` in 1: the serializer can accept one packet.
- `queues_to_serializer_valid` in 1: one-cycle pulse from the queueing domain marking delivery of the granted packet.
- `scheduler_to_queues_ready` out 1: one-cycle request pulse to the queueing domain. Its rising edge pops the head of queue `core_id`.
- `core_id` out `$clog2(NUMBER_OF_QUEUES)`: selected queue. Held stable from GRANT through WAIT.
- `busy` out 1: high in GRANT and WAIT.
- `deadline_miss` out `NUMBER_OF_QUEUES`: sticky per-queue flag. Cleared only by reset.

## Operation
- Slack counter per queue, `slack[i]`, REGISTER_SIZE bits:
  - `empty[i]`=1: `slack[i] <= queues_period[i]` every cycle.
  - Serviced (valid pulse while `core_id==i`): `slack[i] <= queues_period[i]`.
  - Otherwise: `slack[i] <= slack[i]-1`, saturating at 0.
  - If reload and decrement coincide, reload wins.
- Deadline miss: `deadline_miss[i]` sets when `slack[i]==0`, `empty[i]==0`, and queue i is not being serviced this cycle.
- Winner selection (combinational): among queues with `empty[i]==0`, pick minimum `slack[i]`. Ties go to the lowest index. `queues_period[i]==0` therefore means permanent top priority.
- FSM states: IDLE, GRANT, WAIT.
  - IDLE: if `serializer_ready` and any queue is non-empty, register winner into `core_id` and go to GRANT. Otherwise stay.
  - GRANT: `scheduler_to_queues_ready=1` for exactly one cycle, then go to WAIT.
  - WAIT: on `queues_to_serializer_valid`, reload `slack[core_id]` and go to IDLE.
- Because IDLE always sits between grants, `scheduler_to_queues_ready` is low for at least one cycle between pulses. This guarantees the queueing domain's rising-edge detector fires on every grant.
- `core_id` must not change in GRANT or WAIT; the queue BRAM read address depends on it.
- Reset values: state=IDLE, `scheduler_to_queues_ready`=0, `core_id`=0, `busy`=0, `deadline_miss`=0, all `slack[i]`=0. Slack reloads on the first post-reset cycle from `empty`=1.

## Timing
- Request seen in IDLE at cycle t → GRANT at t+1 (ready high) → WAIT at t+2.
- Valid arrives at t+2 → IDLE at t+3. Peak throughput is one packet per 3 cycles.
- Decision latency is 1 cycle. Slack values used are those registered at cycle t.
- `empty` is re-sampled in IDLE at t+3, after the queue pointer update, so the served queue's flag is current.
- A valid pulse outside WAIT is ignored: no reload, no state change.
- `serializer_ready` dropping in GRANT or WAIT does not abort the transaction.
- Reset asserted in GRANT or WAIT returns to IDLE next edge with all outputs at reset values. The in-flight grant is discarded.

## Configuration
- `EDF_WAIT_TIMEOUT_EN`, defined:
  - adds a 4-bit WAIT watchdog;
  - if no valid pulse arrives within 8 cycles in WAIT, FSM returns to IDLE without reloading slack;
  - the sticky output `timeout_error` (1 bit, reset 0) sets.
- Undefined: WAIT waits indefinitely, and the `timeout_error` port is absent.

## Test plan
- Reset, all `empty`=1, `serializer_ready`=1 → ready never pulses, `busy`=0, `core_id`=0 for 100 cycles.
- Periods {40,10,30,20}; queues 0 and 2 go non-empty together, with valid returned 1 cycle after ready → first grant `core_id`=2, ready pulse 1 cycle wide, IDLE 3 cycles after request.
- Periods all 16; queues 1 and 3 non-empty with equal slack → `core_id`=1 (lowest-index tie-break). After service, slack[1] reloads to 16, so the next grant is `core_id`=3.
- Period[0]=5, queue 0 non-empty, `serializer_ready`=0 for 10 cycles → `deadline_miss[0]` sets at cycle 6 and stays 1 after service.
- Back-to-back: queue 2 with 4 packets, valid always returned → ready pulses exactly 3 cycles apart, with at least 1 low cycle between pulses; `core_id` stable during each GRANT/WAIT.
- With `EDF_WAIT_TIMEOUT_EN`, valid withheld → FSM back to IDLE 8 cycles after entering WAIT, `timeout_error`=1. Reset during WAIT → ready=0, `busy`=0 on the next cycle.

Source files
------------

// File: rtl/edf_memory_scheduler_if.sv
// ----------------------------------------------------------------------------
// edf_memory_scheduler_if
// Bundles the signals exchanged between the EDF scheduler, the queueing
// domain and the serializer of one MemorEDF port.
//
//   queues_period              per-queue relative deadline (cycles)
//   empty                      per-queue empty flags
//   serializer_ready           serializer can take one packet
//   queues_to_serializer_valid one-cycle delivery pulse for the granted packet
//   scheduler_to_queues_ready  one-cycle pop request towards queue core_id
//   core_id                    selected queue, stable through GRANT/WAIT
//   busy                       transaction in flight (GRANT or WAIT)
//   deadline_miss              sticky per-queue deadline-miss flags
//   timeout_error              sticky WAIT-watchdog flag (EDF_WAIT_TIMEOUT_EN only)
//
// Modports: master = environment side, slave = the scheduler.
// Optional feature macro: EDF_WAIT_TIMEOUT_EN.
// ----------------------------------------------------------------------------
interface edf_memory_scheduler_if #(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int REGISTER_SIZE    = 32
);
  localparam int ID_W = $clog2(NUMBER_OF_QUEUES);

  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0] queues_period;
  logic [NUMBER_OF_QUEUES-1:0]                    empty;
  logic                                           serializer_ready;
  logic                                           queues_to_serializer_valid;
  logic                                           scheduler_to_queues_ready;
  logic [ID_W-1:0]                                core_id;
  logic                                           busy;
  logic [NUMBER_OF_QUEUES-1:0]                    deadline_miss;
`ifdef EDF_WAIT_TIMEOUT_EN
  logic                                           timeout_error;

  modport master (
    output queues_period, empty, serializer_ready, queues_to_serializer_valid,
    input  scheduler_to_queues_ready, core_id, busy, deadline_miss, timeout_error
  );
  modport slave (
    input  queues_period, empty, serializer_ready, queues_to_serializer_valid,
    output scheduler_to_queues_ready, core_id, busy, deadline_miss, timeout_error
  );
`else
  modport master (
    output queues_period, empty, serializer_ready, queues_to_serializer_valid,
    input  scheduler_to_queues_ready, core_id, busy, deadline_miss
  );
  modport slave (
    input  queues_period, empty, serializer_ready, queues_to_serializer_valid,
    output scheduler_to_queues_ready, core_id, busy, deadline_miss
  );
`endif
endinterface

// File: rtl/edf_memory_scheduler.sv
// ----------------------------------------------------------------------------
// edf_memory_scheduler
// Earliest-deadline-first arbiter for the MemorEDF queueing domain. Each
// per-core queue owns a saturating slack countdown; the non-empty queue with
// the smallest slack (lowest index on ties) is granted. A grant is a
// one-cycle scheduler_to_queues_ready pulse, after which the block waits for
// queues_to_serializer_valid before arbitrating again.
//
// Ports:
//   clock  single clock
//   reset  synchronous, active-high
//   bus    edf_memory_scheduler_if.slave (see interface file for signals)
//
// Optional feature macro: EDF_WAIT_TIMEOUT_EN -- adds an 8-cycle WAIT
// watchdog and the sticky timeout_error output.
// ----------------------------------------------------------------------------
module edf_memory_scheduler #(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int REGISTER_SIZE    = 32
) (
  input logic                    clock,
  input logic                    reset,
  edf_memory_scheduler_if.slave  bus
);
  localparam int ID_W = $clog2(NUMBER_OF_QUEUES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [ID_W-1:0]             core_id_q, core_id_d;
  logic [REGISTER_SIZE-1:0]    slack_q [NUMBER_OF_QUEUES];
  logic [REGISTER_SIZE-1:0]    slack_d [NUMBER_OF_QUEUES];
  logic [NUMBER_OF_QUEUES-1:0] miss_q, miss_d;
  logic [NUMBER_OF_QUEUES-1:0] service;
  logic [NUMBER_OF_QUEUES-1:0] miss_set;
  logic                        accept;

  logic                        win_found;
  logic [ID_W-1:0]             win_idx;
  logic [REGISTER_SIZE-1:0]    win_slack;

  // Delivery only counts while a grant is outstanding; stray pulses are ignored.
  assign accept = (state_q == S_WAIT) && bus.queues_to_serializer_valid;

  // --------------------------------------------------------------------------
  // Per-queue slack countdown and deadline-miss detection
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUMBER_OF_QUEUES; gi++) begin : g_queue
      assign service[gi] = accept && (core_id_q == ID_W'(gi));

      // Reload has priority over the decrement; the countdown saturates at 0.
      assign slack_d[gi] = (bus.empty[gi] || service[gi]) ? bus.queues_period[gi] :
                           (slack_q[gi] == '0)            ? '0 :
                                                            slack_q[gi] - 1'b1;

      assign miss_set[gi] = (slack_q[gi] == '0) && !bus.empty[gi] && !service[gi];
    end
  endgenerate

  assign miss_d = miss_q | miss_set;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUMBER_OF_QUEUES; i++) slack_q[i] <= '0;
      miss_q <= '0;
    end else begin
      for (int i = 0; i < NUMBER_OF_QUEUES; i++) slack_q[i] <= slack_d[i];
      miss_q <= miss_d;
    end
  end

  // --------------------------------------------------------------------------
  // Winner: minimum slack among non-empty queues. Strict '<' keeps the
  // lowest index on ties; win_found avoids relying on an all-ones sentinel.
  // --------------------------------------------------------------------------
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_slack = '0;
    for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
      if (!bus.empty[i] && (!win_found || (slack_q[i] < win_slack))) begin
        win_found = 1'b1;
        win_idx   = ID_W'(i);
        win_slack = slack_q[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Optional WAIT watchdog
  // --------------------------------------------------------------------------
`ifdef EDF_WAIT_TIMEOUT_EN
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_q, timeout_d;
  logic       wait_expired;

  // wait_cnt counts completed WAIT cycles; the 8th silent cycle expires it.
  assign wait_expired = (state_q == S_WAIT) && !bus.queues_to_serializer_valid &&
                        (wait_cnt_q == 4'd7);
  assign wait_cnt_d   = (state_q == S_WAIT) ? wait_cnt_q + 4'd1 : 4'd0;
  assign timeout_d    = timeout_q | wait_expired;

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt_q <= 4'd0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.timeout_error = timeout_q;
`endif

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    core_id_d = core_id_q;
    case (state_q)
      S_IDLE: begin
        // core_id only ever changes here, so it is frozen for GRANT/WAIT.
        if (bus.serializer_ready && win_found) begin
          core_id_d = win_idx;
          state_d   = S_GRANT;
        end
      end
      S_GRANT: state_d = S_WAIT;
      S_WAIT: begin
        if (accept) begin
          state_d = S_IDLE;
        end
`ifdef EDF_WAIT_TIMEOUT_EN
        else if (wait_expired) begin
          state_d = S_IDLE;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      core_id_q <= '0;
    end else begin
      state_q   <= state_d;
      core_id_q <= core_id_d;
    end
  end

  // Ready is decoded from the GRANT state, so it is exactly one cycle wide and
  // always separated from the next pulse by at least one IDLE cycle.
  assign bus.scheduler_to_queues_ready = (state_q == S_GRANT);
  assign bus.busy                      = (state_q != S_IDLE);
  assign bus.core_id                   = core_id_q;
  assign bus.deadline_miss             = miss_q;

endmodule

// File: tb/tb_edf_memory_scheduler.sv
module tb_edf_memory_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  edf_memory_scheduler_if #(.NUMBER_OF_QUEUES(4), .REGISTER_SIZE(32)) bus ();

  edf_memory_scheduler #(.NUMBER_OF_QUEUES(4), .REGISTER_SIZE(32)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one cycle; all sampling and driving happens 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ready_cnt, busy_cnt, core_nz;
    int pkts, core_bad;
    int pulses[$];
    logic prev_rdy;

    bus.queues_period = '{32'd16, 32'd16, 32'd16, 32'd16};
    bus.empty = 4'b1111;
    bus.serializer_ready = 1'b1;
    bus.queues_to_serializer_valid = 1'b0;
    rst = 1'b1;
    step();
    step();
    check("rst_ready", bus.scheduler_to_queues_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_core", bus.core_id, 0);
    check("rst_miss", bus.deadline_miss, 0);
    rst = 1'b0;

    // ---- Test 1: all empty for 100 cycles ----
    $display("test1: idle with all queues empty");
    ready_cnt = 0; busy_cnt = 0; core_nz = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (bus.scheduler_to_queues_ready !== 1'b0) ready_cnt++;
      if (bus.busy !== 1'b0) busy_cnt++;
      if (bus.core_id !== 2'd0) core_nz++;
    end
    check("t1_ready_pulses", ready_cnt, 0);
    check("t1_busy_cycles", busy_cnt, 0);
    check("t1_core_nonzero", core_nz, 0);

    // ---- Test 2: periods {40,10,30,20}, queues 0 and 2 non-empty ----
    $display("test2: EDF pick between queues 0 and 2");
    bus.queues_period[0] = 32'd40;
    bus.queues_period[1] = 32'd10;
    bus.queues_period[2] = 32'd30;
    bus.queues_period[3] = 32'd20;
    step();                          // slack reload while empty
    bus.empty = 4'b1010;             // cycle t
    step();                          // t+1: GRANT
    check("t2_grant_ready", bus.scheduler_to_queues_ready, 1);
    check("t2_grant_busy", bus.busy, 1);
    check("t2_grant_core", bus.core_id, 2);
    $display("grant core=%0d", bus.core_id);
    step();                          // t+2: WAIT
    check("t2_wait_ready", bus.scheduler_to_queues_ready, 0);
    check("t2_wait_busy", bus.busy, 1);
    check("t2_wait_core", bus.core_id, 2);
    bus.queues_to_serializer_valid = 1'b1;
    bus.empty = 4'b1110;             // queue 2 drained by the pop
    step();                          // t+3: IDLE
    bus.queues_to_serializer_valid = 1'b0;
    check("t2_idle_busy", bus.busy, 0);
    check("t2_idle_ready", bus.scheduler_to_queues_ready, 0);
    step();                          // GRANT for queue 0
    check("t2_second_core", bus.core_id, 0);
    check("t2_second_ready", bus.scheduler_to_queues_ready, 1);
    $display("grant core=%0d", bus.core_id);
    step();
    bus.queues_to_serializer_valid = 1'b1;
    bus.empty = 4'b1111;
    step();
    bus.queues_to_serializer_valid = 1'b0;
    check("t2_no_miss", bus.deadline_miss, 0);

    // ---- Test 3: equal slack tie-break, then reload reorders ----
    $display("test3: tie-break and reload");
    bus.queues_period = '{32'd16, 32'd16, 32'd16, 32'd16};
    step();
    bus.empty = 4'b0101;
    step();                          // GRANT
    check("t3_tie_core", bus.core_id, 1);
    $display("grant core=%0d", bus.core_id);
    bus.queues_to_serializer_valid = 1'b1;   // pulse in GRANT must be ignored
    step();                          // WAIT
    bus.queues_to_serializer_valid = 1'b0;
    check("t3_wait_busy", bus.busy, 1);
    check("t3_wait_ready", bus.scheduler_to_queues_ready, 0);
    step();                          // still WAIT
    check("t3_still_wait", bus.busy, 1);
    bus.queues_to_serializer_valid = 1'b1;
    step();                          // IDLE
    bus.queues_to_serializer_valid = 1'b0;
    check("t3_idle_busy", bus.busy, 0);
    step();                          // GRANT: slack[1]=16 vs slack[3]=12
    check("t3_next_core", bus.core_id, 3);
    check("t3_next_ready", bus.scheduler_to_queues_ready, 1);
    $display("grant core=%0d", bus.core_id);
    step();
    bus.queues_to_serializer_valid = 1'b1;
    bus.empty = 4'b1111;
    step();
    bus.queues_to_serializer_valid = 1'b0;

    // ---- Test 4: deadline miss with serializer stalled ----
    $display("test4: deadline miss");
    bus.serializer_ready = 1'b0;
    bus.queues_period[0] = 32'd5;
    step();
    bus.empty = 4'b1110;             // cycle 0, slack[0]=5
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("t4_miss_c%0d", k), bus.deadline_miss[0], (k >= 6) ? 1 : 0);
    end
    bus.serializer_ready = 1'b1;
    step();
    check("t4_grant_core", bus.core_id, 0);
    $display("grant core=%0d", bus.core_id);
    step();
    bus.queues_to_serializer_valid = 1'b1;
    bus.empty = 4'b1111;
    step();
    bus.queues_to_serializer_valid = 1'b0;
    check("t4_miss_sticky", bus.deadline_miss, 4'b0001);

    // ---- Test 5: back-to-back grants on queue 2 ----
    $display("test5: back-to-back on queue 2");
    bus.queues_period = '{32'd16, 32'd16, 32'd16, 32'd16};
    pkts = 4; core_bad = 0; prev_rdy = 1'b0;
    bus.empty = 4'b1011;
    for (int c = 0; c < 30; c++) begin
      step();
      bus.queues_to_serializer_valid = 1'b0;
      if (bus.busy === 1'b1 && bus.core_id !== 2'd2) core_bad++;
      if (prev_rdy) begin
        bus.queues_to_serializer_valid = 1'b1;
        pkts--;
        if (pkts == 0) bus.empty = 4'b1111;
      end
      if (bus.scheduler_to_queues_ready === 1'b1) begin
        pulses.push_back(c);
        $display("grant core=%0d cycle=%0d", bus.core_id, c);
      end
      prev_rdy = bus.scheduler_to_queues_ready;
    end
    bus.queues_to_serializer_valid = 1'b0;
    check("t5_pulse_count", pulses.size(), 4);
    for (int i = 1; i < pulses.size(); i++)
      check($sformatf("t5_gap%0d", i), pulses[i] - pulses[i-1], 3);
    check("t5_core_stable", core_bad, 0);

    // ---- Test 6: reset during WAIT ----
    $display("test6: reset during WAIT");
    bus.empty = 4'b1011;
    step();
    check("t6_grant_core", bus.core_id, 2);
    step();
    check("t6_wait_busy", bus.busy, 1);
    check("t6_miss_before", bus.deadline_miss, 4'b0001);
    rst = 1'b1;
    bus.empty = 4'b1111;
    step();
    check("t6_rst_ready", bus.scheduler_to_queues_ready, 0);
    check("t6_rst_busy", bus.busy, 0);
    check("t6_rst_core", bus.core_id, 0);
    check("t6_rst_miss", bus.deadline_miss, 0);
    rst = 1'b0;
    step();

`ifdef EDF_WAIT_TIMEOUT_EN
    // ---- Test 7: WAIT watchdog ----
    $display("test7: wait timeout");
    check("t7_timeout_init", bus.timeout_error, 0);
    bus.empty = 4'b0111;
    step();                          // GRANT
    check("t7_grant_core", bus.core_id, 3);
    step();                          // WAIT entry (w0)
    for (int k = 1; k <= 7; k++) step();
    check("t7_wait_at7", bus.busy, 1);
    check("t7_timeout_at7", bus.timeout_error, 0);
    step();                          // w0+8: IDLE
    check("t7_idle_at8", bus.busy, 0);
    check("t7_timeout_set", bus.timeout_error, 1);
    bus.empty = 4'b1111;
    step();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
